music_play_ctrl: RTL and testbench

//  Front-end controller for the buzzer music player. Debounces the raw PLAY and NEXT keys,

---
 rtl/music_pkg.sv | 19 +
 rtl/music_play_ctrl_if.sv | 27 ++
 rtl/key_debounce.sv | 56 +++++
 rtl/music_play_ctrl.sv | 99 +++++++++
 tb/tb_music_play_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/music_pkg.sv
// Shared types and helpers for the buzzer music player front end.
// State encoding and debounce period arithmetic live here.
package music_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_PAUSE = 2'd3
  } state_e;

  function automatic int deb_cyc(
    input int clk_fre,
    input int ms
  );
    return clk_fre / 1000 * ms;
  endfunction

endpackage

// File: rtl/music_play_ctrl_if.sv
// Controller <-> player bundle: start pulse, run level,
// song index, status LED and end-of-song pulse.
interface music_play_ctrl_if #(
  parameter int SONG_W = 2
);
  logic              play_done;
  logic              play_en;
  logic              start_stop;
  logic [SONG_W-1:0] song_sel;
  logic              playing;

  modport master (
    input  play_done,
    output play_en,
    output start_stop,
    output song_sel,
    output playing
  );

  modport slave (
    output play_done,
    input  play_en,
    input  start_stop,
    input  song_sel,
    input  playing
  );
endinterface

// File: rtl/key_debounce.sv
// Active-low key synchroniser and debouncer.
// Emits a single-cycle pulse on each debounced press.
module key_debounce
  import music_pkg::*;
#(
  parameter int CLK_FRE     = 50_000_000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic press_pulse
);
  localparam int DEB_CYC = deb_cyc(CLK_FRE, DEBOUNCE_MS);
  localparam int CW = $clog2(DEB_CYC > 1 ? DEB_CYC : 2);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    // count only samples that disagree with the level
    if (s2_q != level_q) begin
      if (cnt_q == CW'(DEB_CYC - 1)) begin
        level_d = s2_q;
        press_d = ~s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= key_n;
      s2_q    <= s1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_level   = level_q;
  assign press_pulse = press_q;
endmodule

// File: rtl/music_play_ctrl.sv
// Key-driven play/pause/next controller for the buzzer player.
// Song changes are deferred until the player reports done.
module music_play_ctrl
  import music_pkg::*;
#(
  parameter int CLK_FRE     = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int SONG_NUM    = 4,
  parameter int SONG_W      = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key_play,
  input  logic key_next,
  input  logic repeat_en,
  music_play_ctrl_if.master bus
);
  logic play_ev, next_ev;
  logic play_lvl, next_lvl;

  state_e            state_q, state_d;
  logic [SONG_W-1:0] song_q, song_d, song_inc;
  logic              pend_q, pend_d;

  key_debounce #(
    .CLK_FRE    (CLK_FRE),
    .DEBOUNCE_MS(DEBOUNCE_MS)
  ) u_play (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_play),
    .key_level  (play_lvl),
    .press_pulse(play_ev)
  );

  key_debounce #(
    .CLK_FRE    (CLK_FRE),
    .DEBOUNCE_MS(DEBOUNCE_MS)
  ) u_next (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_next),
    .key_level  (next_lvl),
    .press_pulse(next_ev)
  );

  assign song_inc = (song_q == SONG_W'(SONG_NUM - 1))
                  ? '0 : song_q + SONG_W'(1);

  always_comb begin
    state_d = state_q;
    song_d  = song_q;
    pend_d  = pend_q;
    unique case (state_q)
      S_IDLE: begin
        if (next_ev) song_d = song_inc;
        if (play_ev) state_d = S_START;
      end
      S_START: begin
        state_d = S_RUN;
        if (next_ev) pend_d = 1'b1;
      end
      S_RUN, S_PAUSE: begin
        // end of song wins over a same-cycle key press
        if (bus.play_done) begin
          if (pend_q) song_d = song_inc;
          pend_d  = 1'b0;
          state_d = repeat_en ? S_START : S_IDLE;
        end else begin
          if (next_ev) pend_d = 1'b1;
          if (play_ev)
            state_d = (state_q == S_RUN) ? S_PAUSE : S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      song_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      song_q  <= song_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.play_en    = (state_q == S_START);
  assign bus.start_stop = (state_q == S_START) ||
                          (state_q == S_RUN);
  assign bus.song_sel   = song_q;
  assign bus.playing    = (state_q != S_IDLE);

  logic unused_lvl;
  assign unused_lvl = play_lvl ^ next_lvl;
endmodule

// File: tb/tb_music_play_ctrl.sv
// Bench for music_play_ctrl: behavioural model compared each cycle
// plus directed key/done scenarios with literal expectations.
module tb_music_play_ctrl;
  localparam int DEB      = 8;
  localparam int SONG_NUM = 4;
  localparam int SONG_W   = 2;

  logic clk = 1'b0;
  logic rst;
  logic key_play, key_next, repeat_en;

  always #5 clk = ~clk;

  music_play_ctrl_if #(.SONG_W(SONG_W)) bus ();

  music_play_ctrl #(
    .CLK_FRE    (8000),
    .DEBOUNCE_MS(1),
    .SONG_NUM   (SONG_NUM),
    .SONG_W     (SONG_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_play (key_play),
    .key_next (key_next),
    .repeat_en(repeat_en),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;
  int pe_cnt = 0;
  bit cmp_en = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---- behavioural model ----
  logic [1:0]     mp_sync, mn_sync;
  logic [DEB-1:0] mp_hist, mn_hist;
  logic           mp_lvl, mn_lvl, m_pev, m_nev;
  int             m_mode, m_song;
  bit             m_pend;
  wire [DEB-1:0]  mp_new = {mp_hist[DEB-2:0], mp_sync[1]};
  wire [DEB-1:0]  mn_new = {mn_hist[DEB-2:0], mn_sync[1]};

  // a level flips once the last DEB synced samples all disagree with it
  always @(posedge clk) begin
    if (rst) begin
      mp_sync <= 2'b11; mn_sync <= 2'b11;
      mp_hist <= '1;    mn_hist <= '1;
      mp_lvl  <= 1'b1;  mn_lvl  <= 1'b1;
      m_pev   <= 1'b0;  m_nev   <= 1'b0;
    end else begin
      mp_sync <= {mp_sync[0], key_play};
      mn_sync <= {mn_sync[0], key_next};
      mp_hist <= mp_new;
      mn_hist <= mn_new;
      m_pev   <= 1'b0;
      m_nev   <= 1'b0;
      if (&mp_new && !mp_lvl) mp_lvl <= 1'b1;
      else if (~|mp_new && mp_lvl) begin
        mp_lvl <= 1'b0; m_pev <= 1'b1;
      end
      if (&mn_new && !mn_lvl) mn_lvl <= 1'b1;
      else if (~|mn_new && mn_lvl) begin
        mn_lvl <= 1'b0; m_nev <= 1'b1;
      end
    end
  end

  // mode: 0 idle, 1 start, 2 run, 3 pause
  always @(posedge clk) begin
    if (rst) begin
      m_mode <= 0; m_song <= 0; m_pend <= 0;
    end else begin
      case (m_mode)
        0: begin
          if (m_nev) m_song <= (m_song + 1) % SONG_NUM;
          if (m_pev) m_mode <= 1;
        end
        1: begin
          m_mode <= 2;
          if (m_nev) m_pend <= 1;
        end
        default: begin
          if (bus.play_done) begin
            if (m_pend) m_song <= (m_song + 1) % SONG_NUM;
            m_pend <= 0;
            m_mode <= repeat_en ? 1 : 0;
          end else begin
            if (m_nev) m_pend <= 1;
            if (m_pev) m_mode <= (m_mode == 2) ? 3 : 2;
          end
        end
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      check("m_play_en", int'(bus.play_en), int'(m_mode == 1));
      check("m_start_stop", int'(bus.start_stop),
            int'(m_mode == 1 || m_mode == 2));
      check("m_song_sel", int'(bus.song_sel), m_song);
      check("m_playing", int'(bus.playing), int'(m_mode != 0));
      if (bus.play_en === 1'b1) pe_cnt++;
    end
  end

  // ---- directed stimulus ----
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press_play(input int hold);
    key_play = 1'b0; step(hold);
    key_play = 1'b1; step(14);
  endtask

  task automatic press_next();
    key_next = 1'b0; step(12);
    key_next = 1'b1; step(14);
  endtask

  task automatic pulse_done();
    bus.play_done = 1'b1; step(1);
    bus.play_done = 1'b0; step(3);
  endtask

  int base;
  int exp_song [5] = '{1, 2, 3, 0, 1};
  bit seen;

  initial begin
    rst = 1'b1; key_play = 1'b1; key_next = 1'b1;
    repeat_en = 1'b0; bus.play_done = 1'b0;
    step(2);
    cmp_en = 1;
    rst = 1'b0;
    check("rst_play_en", int'(bus.play_en), 0);
    check("rst_start_stop", int'(bus.start_stop), 0);
    check("rst_song_sel", int'(bus.song_sel), 0);
    check("rst_playing", int'(bus.playing), 0);

    // 1: bounce rejected, then one real press
    key_play = 1'b0; step(3);
    key_play = 1'b1; step(14);
    check("bounce_playing", int'(bus.playing), 0);
    check("bounce_pe", pe_cnt, 0);
    press_play(20);
    check("t1_pe", pe_cnt, 1);
    check("t1_start_stop", int'(bus.start_stop), 1);
    check("t1_playing", int'(bus.playing), 1);

    // 2: pause and resume
    press_play(12);
    check("t2_pause_ss", int'(bus.start_stop), 0);
    check("t2_pause_playing", int'(bus.playing), 1);
    press_play(12);
    check("t2_resume_ss", int'(bus.start_stop), 1);
    check("t2_no_new_pe", pe_cnt, 1);
    pulse_done();
    check("t2_idle_playing", int'(bus.playing), 0);

    // 3: next in idle wraps at SONG_NUM
    for (int i = 0; i < 5; i++) begin
      press_next();
      check($sformatf("t3_song%0d", i), int'(bus.song_sel), exp_song[i]);
    end

    // 4: next while busy is deferred and not doubled
    press_next();
    check("t4_song_pre", int'(bus.song_sel), 2);
    press_play(12);
    check("t4_pe", pe_cnt, 2);
    press_next();
    press_next();
    check("t4_song_held", int'(bus.song_sel), 2);
    pulse_done();
    step(4);
    check("t4_song_after", int'(bus.song_sel), 3);
    check("t4_playing", int'(bus.playing), 0);
    check("t4_start_stop", int'(bus.start_stop), 0);
    check("t4_no_pe", pe_cnt, 2);

    // 5: auto-repeat latency, then done beats a same-cycle play event
    press_play(12);
    repeat_en = 1'b1;
    base = pe_cnt;
    bus.play_done = 1'b1; step(1);
    bus.play_done = 1'b0;
    check("t5_pe_t1", int'(bus.play_en), 1);
    check("t5_ss_t1", int'(bus.start_stop), 1);
    step(1);
    check("t5_pe_t2", int'(bus.play_en), 0);
    check("t5_ss_t2", int'(bus.start_stop), 1);
    step(3);
    check("t5_pe_count", pe_cnt - base, 1);

    key_play = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1);
      seen = m_pev;
    end
    check("t5_ev_timeout", int'(seen), 1);
    bus.play_done = 1'b1; step(1);
    bus.play_done = 1'b0; step(4);
    key_play = 1'b1; step(14);
    check("t5_coinc_ss", int'(bus.start_stop), 1);
    check("t5_coinc_playing", int'(bus.playing), 1);
    check("t5_coinc_song", int'(bus.song_sel), 3);
    check("t5_coinc_pe", pe_cnt - base, 2);

    // 6: reset while paused
    repeat_en = 1'b0;
    press_play(12);
    check("t6_paused_ss", int'(bus.start_stop), 0);
    check("t6_song_pre", int'(bus.song_sel), 3);
    base = pe_cnt;
    rst = 1'b1; step(1);
    rst = 1'b0;
    check("t6_play_en", int'(bus.play_en), 0);
    check("t6_start_stop", int'(bus.start_stop), 0);
    check("t6_song_sel", int'(bus.song_sel), 0);
    check("t6_playing", int'(bus.playing), 0);
    step(5);
    check("t6_no_pe", pe_cnt - base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
